// File: rtl/nrzi_unstuff_down.sv
// Receive front end: NRZI decode, bit unstuffing and SOP/EOP detection on the dp/dm line.
// Define SIE_DOWN_LINE_SYNC_EN to pass dp/dm through a 2-flop synchroniser before sampling.
module nrzi_unstuff_down #(
    parameter int ONES_LIMIT   = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic dp,
    input  logic dm,
    output logic serial_in,
    output logic is_stuffed,
    output logic in_transmission,
    output logic end_transmission,
    output logic rx_err
);

    localparam int CW = $clog2(ONES_LIMIT + 1);
    localparam logic [CW-1:0] ONES_MAX = CW'(ONES_LIMIT);
    localparam logic [2:0]    EOP_MIN  = 3'(EOP_SE0_BITS);

    typedef enum logic [1:0] {IDLE, ACTIVE, EOP, DRAIN} state_t;
    // Encoded as {dp, dm}
    typedef enum logic [1:0] {L_SE0 = 2'b00, L_K = 2'b01, L_J = 2'b10, L_SE1 = 2'b11} line_t;

    line_t line;

`ifdef SIE_DOWN_LINE_SYNC_EN
    logic [1:0][1:0] sync_q, sync_d;

    always_comb begin
        sync_d[0] = {dp, dm};
        sync_d[1] = sync_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2'b10, 2'b10};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign line = line_t'(sync_q[1]);
`else
    assign line = line_t'({dp, dm});
`endif

    state_t        state_q, state_d;
    line_t         prev_q, prev_d;
    logic [CW-1:0] ones_q, ones_d;
    logic [2:0]    se0_q, se0_d;
    logic          serial_q, serial_d;
    logic          stuffed_q, stuffed_d;
    logic          in_tx_q, in_tx_d;
    logic          end_q, end_d;
    logic          err_q, err_d;
    logic          bit_v;
    logic          abort;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        ones_d    = ones_q;
        se0_d     = se0_q;
        serial_d  = serial_q;
        stuffed_d = stuffed_q;
        in_tx_d   = in_tx_q;
        end_d     = 1'b0;
        err_d     = 1'b0;
        abort     = 1'b0;
        bit_v     = (line == prev_q);

        case (state_q)
            IDLE: begin
                if (line == L_K) begin
                    state_d   = ACTIVE;
                    in_tx_d   = 1'b1;
                    serial_d  = 1'b0;
                    stuffed_d = 1'b0;
                    ones_d    = '0;
                    prev_d    = L_K;
                end
            end
            ACTIVE: begin
                case (line)
                    L_J, L_K: begin
                        prev_d   = line;
                        serial_d = bit_v;
                        if (ones_q == ONES_MAX) begin
                            // Bit after a full run of ones must be a transition
                            stuffed_d = 1'b1;
                            ones_d    = '0;
                            abort     = bit_v;
                        end else begin
                            stuffed_d = 1'b0;
                            ones_d    = bit_v ? ones_q + 1'b1 : '0;
                        end
                    end
                    L_SE0: begin
                        state_d   = EOP;
                        se0_d     = 3'd1;
                        stuffed_d = 1'b0;
                    end
                    default: abort = 1'b1;
                endcase
            end
            EOP: begin
                case (line)
                    L_SE0: se0_d = (se0_q == 3'd7) ? 3'd7 : se0_q + 3'd1;
                    L_J: begin
                        if (se0_q >= EOP_MIN) begin
                            end_d   = 1'b1;
                            in_tx_d = 1'b0;
                            prev_d  = L_J;
                            state_d = IDLE;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                    default: abort = 1'b1;
                endcase
            end
            DRAIN: begin
                // se0_q doubles as the "SE0 seen" flag while draining
                case (line)
                    L_SE0: se0_d = 3'd1;
                    L_J: begin
                        if (se0_q != 3'd0) begin
                            state_d = IDLE;
                            prev_d  = L_J;
                        end
                    end
                    default: se0_d = 3'd0;
                endcase
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d   = DRAIN;
            serial_d  = serial_q;
            stuffed_d = 1'b0;
            in_tx_d   = 1'b0;
            end_d     = 1'b1;
            err_d     = 1'b1;
            se0_d     = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prev_q    <= L_J;
            ones_q    <= '0;
            se0_q     <= '0;
            serial_q  <= 1'b1;
            stuffed_q <= 1'b0;
            in_tx_q   <= 1'b0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            ones_q    <= ones_d;
            se0_q     <= se0_d;
            serial_q  <= serial_d;
            stuffed_q <= stuffed_d;
            in_tx_q   <= in_tx_d;
            end_q     <= end_d;
            err_q     <= err_d;
        end
    end

    assign serial_in        = serial_q;
    assign is_stuffed       = stuffed_q;
    assign in_transmission  = in_tx_q;
    assign end_transmission = end_q;
    assign rx_err           = err_q;

endmodule

// File: tb/tb_nrzi_unstuff_down.sv
// Scoreboard bench: packets are built from bytes, stuffed and NRZI-encoded here, and the
// expected per-bit decoder outputs are queued for a monitor that checks each en edge.
module tb_nrzi_unstuff_down;

    logic clk = 1'b0;
    logic rst_n, en, dp, dm;
    logic serial_in, is_stuffed, in_transmission, end_transmission, rx_err;

    nrzi_unstuff_down dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dp(dp), .dm(dm),
        .serial_in(serial_in), .is_stuffed(is_stuffed), .in_transmission(in_transmission),
        .end_transmission(end_transmission), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00, LSE1 = 2'b11;

    typedef struct {
        logic in_tx, ser, stf, endt, err, care;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] lvl;
    logic hold_ser;
    logic fresh;

    function automatic exp_t mk(logic in_tx, logic ser, logic stf, logic endt, logic err, logic care);
        exp_t e;
        e.in_tx = in_tx; e.ser = ser; e.stf = stf; e.endt = endt; e.err = err; e.care = care;
        return e;
    endfunction

    function automatic void chk(string nm, logic a, logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%b want=%b t=%0t", nm, a, e, $time);
        end
    endfunction

    function automatic void cmp(string t, exp_t e);
        chk({t, ".in_transmission"}, in_transmission, e.in_tx);
        chk({t, ".is_stuffed"}, is_stuffed, e.stf);
        chk({t, ".end_transmission"}, end_transmission, e.endt);
        chk({t, ".rx_err"}, rx_err, e.err);
        if (e.care) chk({t, ".serial_in"}, serial_in, e.ser);
    endfunction

    always @(posedge clk) begin
        if (en && rst_n) begin
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL underflow got=en_edge want=no_edge t=%0t", $time);
            end else begin
                mon_e = q.pop_front();
                cmp("mon", mon_e);
            end
        end
    end

    // One bit period: line set, en low for a few clocks (outputs must hold), then one en edge
    task automatic drive_bit(input logic [1:0] l, input exp_t e);
        @(negedge clk);
        {dp, dm} = l;
        en = 1'b0;
        repeat ($urandom_range(2, 4)) @(negedge clk);
        cmp("hold", last_exp);
        q.push_back(e);
        last_exp = e;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    function automatic exp_t idle_e();
        return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, fresh);
    endfunction

    task automatic send_data(input logic b, input logic stuffed);
        if (!b) lvl = (lvl == LJ) ? LK : LJ;
        hold_ser = b;
        drive_bit(lvl, mk(1'b1, b, stuffed, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic idle(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 7);
            drive_bit((r == 0) ? LSE0 : (r == 1) ? LSE1 : LJ, idle_e());
        end
        lvl = LJ;
    endtask

    task automatic drain();
        int n;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) drive_bit($urandom_range(0, 1) ? LJ : LK, idle_e());
        drive_bit(LSE0, idle_e());
        drive_bit(LJ, idle_e());
        lvl = LJ;
    endtask

    task automatic send_stream(input logic [7:0] pid, input int nbytes);
        logic [7:0] bytes[$];
        logic [7:0] b;
        int ones;
        bytes.push_back(8'h80);
        bytes.push_back(pid);
        for (int i = 0; i < nbytes; i++)
            bytes.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
        fresh = 1'b0;
        lvl = LJ;
        ones = 0;
        foreach (bytes[k]) begin
            b = bytes[k];
            for (int j = 0; j < 8; j++) begin
                send_data(b[j], 1'b0);
                ones = b[j] ? ones + 1 : 0;
                if (ones == 6) begin
                    send_data(1'b0, 1'b1);
                    ones = 0;
                end
            end
        end
    endtask

    // kind: 0 good EOP, 1 stuff error, 2 single-SE0 EOP, 3 SE1 mid-packet, 4 K inside EOP
    task automatic send_packet(input int kind, input logic [7:0] pid, input int nbytes);
        exp_t ab;
        ab = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_stream(pid, nbytes);
        case (kind)
            0: begin
                int n;
                n = $urandom_range(2, 9);
                for (int i = 0; i < n; i++) drive_bit(LSE0, mk(1'b1, hold_ser, 1'b0, 1'b0, 1'b0, 1'b1));
                drive_bit(LJ, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
                lvl = LJ;
            end
            1: begin
                send_data(1'b0, 1'b0);
                for (int i = 0; i < 6; i++) send_data(1'b1, 1'b0);
                drive_bit(lvl, ab);
                drain();
            end
            2: begin
                drive_bit(LSE0, mk(1'b1, hold_ser, 1'b0, 1'b0, 1'b0, 1'b1));
                drive_bit(LJ, ab);
                drain();
            end
            3: begin
                drive_bit(LSE1, ab);
                drain();
            end
            default: begin
                drive_bit(LSE0, mk(1'b1, hold_ser, 1'b0, 1'b0, 1'b0, 1'b1));
                drive_bit(LSE0, mk(1'b1, hold_ser, 1'b0, 1'b0, 1'b0, 1'b1));
                drive_bit(LK, ab);
                drain();
            end
        endcase
    endtask

    task automatic check_reset_values(input string t);
        chk({t, ".in_transmission"}, in_transmission, 1'b0);
        chk({t, ".serial_in"}, serial_in, 1'b1);
        chk({t, ".is_stuffed"}, is_stuffed, 1'b0);
        chk({t, ".end_transmission"}, end_transmission, 1'b0);
        chk({t, ".rx_err"}, rx_err, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        {dp, dm} = LJ;
        lvl = LJ;
        hold_ser = 1'b1;
        fresh = 1'b1;
        last_exp = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        idle(10);
        send_packet(0, 8'hC3, 2);
        idle(3);
        send_packet(0, 8'hA5, 0);
        idle(2);
        send_packet(1, 8'h69, 1);
        idle(2);
        send_packet(2, 8'hE1, 1);
        idle(2);
        send_packet(3, 8'h2D, 1);
        idle(2);
        send_packet(4, 8'h5A, 0);

        for (int p = 0; p < 40; p++) begin
            idle($urandom_range(1, 4));
            send_packet($urandom_range(0, 4), 8'($urandom), $urandom_range(0, 4));
        end

        // Asynchronous reset mid-packet, between en edges
        idle(2);
        send_stream(8'hC3, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        q.delete();
        fresh = 1'b1;
        lvl = LJ;
        hold_ser = 1'b1;
        last_exp = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        {dp, dm} = LJ;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        send_packet(0, 8'h4B, 2);
        idle(2);

        repeat (3) @(negedge clk);
        chk("drain.queue_empty", q.size() == 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
